regf_bus_arb: RTL
=================

# regf_bus_arb

Round-robin arbiter that shares the single `mem_*` access port of a generated register file (`*_regf`) between `NUM_REQ` independent bus requesters. It forwards one granted access per cycle to the register file. It captures the register file's same-cycle read data and error flag, and returns them to the winning requester one cycle later. An optional per-requester lock keeps the grant for back-to-back accesses, for example read-modify-write sequences. Lock hold time is bounded by `MAX_LOCK`.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `ADDR_W`, default 13: byte address width, matching the regf `mem_addr_i`.
- `DATA_W`, default 32: data width.
- `MAX_LOCK`, default 4: maximum consecutive grants to one locked requester, 1..15.

Ports:
- `main_clk_i`  in  1  clock.
- `main_rst_an_i`  in  1  asynchronous reset, active-low.
- `req_ena_i`  in  [NUM_REQ]  access request, held until granted.
- `req_addr_i`  in  [NUM_REQ][ADDR_W]  byte address.
- `req_wena_i`  in  [NUM_REQ]  1 = write, 0 = read.
- `req_wdata_i`  in  [NUM_REQ][DATA_W]  write data.
- `req_lock_i`  in  [NUM_REQ]  request to keep the grant after this access.
- `req_gnt_o`  out  [NUM_REQ]  one-hot grant; access is issued this cycle.
- `req_rvld_o`  out  [NUM_REQ]  one-hot response valid.
- `req_rdata_o`  out  DATA_W  shared response data.
- `req_err_o`  out  1  shared response error.
- `mem_ena_o`, `mem_addr_o`, `mem_wena_o`, `mem_wdata_o`  out  1/ADDR_W/1/DATA_W  to the regf.
- `mem_rdata_i`, `mem_err_i`  in  DATA_W/1  from the regf, valid in the same cycle as `mem_ena_o`.

## Operation
- **State registers**
  - `ptr_r`: priority pointer, 0..NUM_REQ-1.
  - `lock_vld_r` and `lock_own_r`: locked owner.
  - `lock_cnt_r`: 4 bits.
  - Response registers `rvld_r`, `rdata_r`, `err_r`.
- **Arbitration** (combinational, every cycle)
  - If `lock_vld_r` and `req_ena_i[lock_own_r]`: grant `lock_own_r`.
  - Otherwise: grant the first requesting index found scanning from `ptr_r` upward, wrapping modulo NUM_REQ.
  - No request: `req_gnt_o` = 0 and `mem_ena_o` = 0.
- **Forwarding**
  - `mem_ena_o` is 1 exactly when any grant is issued.
  - `mem_addr_o`, `mem_wena_o` and `mem_wdata_o` are muxed from the granted requester.
  - When idle these three outputs are 0.
  - The block never issues a speculative or idle read, because regf RC fields clear on read.
- **Pointer update** on a grant to index k:
  - If the lock continues (see below): `ptr_r` is unchanged.
  - Otherwise: `ptr_r` <= (k+1) mod NUM_REQ.
- **Lock**
  - On a grant to k with `req_lock_i[k]`=1:
    - If currently not locked to k: `lock_vld_r`<=1, `lock_own_r`<=k, `lock_cnt_r`<=1.
    - If already locked to k: `lock_cnt_r` increments.
  - When a grant brings the count to `MAX_LOCK`: release (`lock_vld_r`<=0) and advance `ptr_r`, even with `req_lock_i`=1.
  - Grant to the owner with `req_lock_i`=0: release after this access.
  - Owner not requesting while locked: release the same cycle, and arbitrate normally from `ptr_r` in that cycle. No idle bubble is held.
- **Response**
  - Next cycle after a grant to k: `rvld_r` = one-hot k and `err_r` = `mem_err_i`.
  - For a read, `rdata_r` = `mem_rdata_i`. For a write, `rdata_r` = 0.
  - Without a grant: `rvld_r` = 0, and `rdata_r`/`err_r` are forced to 0.
- **Reset values**: all registers, `req_rvld_o`, `req_rdata_o` and `req_err_o` are 0; `ptr_r` = 0; unlocked.

## Timing
- Grant is combinational, in the same cycle as `req_ena_i`.
- The requester drops or changes its request only in the cycle after seeing `req_gnt_o`.
- Response latency is exactly 1 cycle after grant.
- Throughput is 1 access per cycle, with no bubbles between requesters.
- Reset assertion mid-burst clears the lock and any pending response immediately (asynchronous). The first grant after release comes from `ptr_r` = 0.
- NUM_REQ-1 = 0 is not supported.

## Test plan
- **Single read:** req0 reads 0x0000 while the regf returns 0x0000_0801 -> same cycle `req_gnt_o`=3'b001 and `mem_addr_o`=0x0000; next cycle `req_rvld_o`=3'b001, `req_rdata_o`=0x0000_0801, `req_err_o`=0.
- **Fairness:** all 3 requesters requesting continuously for 6 cycles, no lock -> grant sequence 0,1,2,0,1,2 with `mem_ena_o`=1 every cycle.
- **Lock bound:** MAX_LOCK=4; req1 holds `req_lock_i`=1 while req0 and req2 request continuously, starting with `ptr_r`=1 -> grants 1,1,1,1,2,0.
- **Error and write:** read 0x0024 with `mem_err_i`=1 -> response `req_err_o`=1 and `req_rdata_o`=0. Write 0xA5 to 0x0004 -> `mem_wdata_o`=0xA5, `mem_wena_o`=1, response with rdata 0 and err 0.
- **Idle:** all `req_ena_i`=0 for 10 cycles -> `mem_ena_o`=0 and `req_rvld_o`=0 throughout; no reads reach the regf.
- **Reset mid-lock:** assert reset during the 2nd locked grant to req2 -> all outputs 0 immediately. After release with req1 and req2 both requesting, the first grant is req1.

Source files
------------

// File: rtl/regf_bus_arb.sv
// rtl/regf_bus_arb.sv - round-robin arbiter sharing one regf mem_* port among NUM_REQ requesters
// Bounded per-requester lock; responses return one cycle after the grant.
module regf_bus_arb #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                             main_clk_i,
    input  logic                             main_rst_an_i,
    input  logic [NUM_REQ-1:0]               req_ena_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]               req_wena_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata_i,
    input  logic [NUM_REQ-1:0]               req_lock_i,
    output logic [NUM_REQ-1:0]               req_gnt_o,
    output logic [NUM_REQ-1:0]               req_rvld_o,
    output logic [DATA_W-1:0]                req_rdata_o,
    output logic                             req_err_o,
    output logic                             mem_ena_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    output logic                             mem_wena_o,
    output logic [DATA_W-1:0]                mem_wdata_o,
    input  logic [DATA_W-1:0]                mem_rdata_i,
    input  logic                             mem_err_i
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_r;
    logic               lock_vld_r;
    logic [PW-1:0]      lock_own_r;
    logic [3:0]         lock_cnt_r;
    logic [NUM_REQ-1:0] rvld_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               err_r;

    logic               w_gnt_vld;
    logic [PW-1:0]      w_gnt_idx;
    logic               w_same_owner;
    logic [3:0]         w_cnt_nxt;
    logic               w_hold;

    // Scan offsets high to low so the smallest offset from ptr_r wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (main_rst_an_i) begin
            if (lock_vld_r && req_ena_i[lock_own_r]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = lock_own_r;
            end else begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_ena_i[PW'((int'(ptr_r) + i) % NUM_REQ)]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = PW'((int'(ptr_r) + i) % NUM_REQ);
                    end
                end
            end
        end
    end

    always_comb begin
        w_same_owner = lock_vld_r && (lock_own_r == w_gnt_idx);
        w_cnt_nxt    = w_same_owner ? lock_cnt_r + 4'd1 : 4'd1;
        w_hold       = w_gnt_vld && req_lock_i[w_gnt_idx] && (w_cnt_nxt < 4'(MAX_LOCK));
    end

    assign req_gnt_o   = w_gnt_vld ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign mem_ena_o   = w_gnt_vld;
    assign mem_addr_o  = w_gnt_vld ? req_addr_i[w_gnt_idx]  : '0;
    assign mem_wena_o  = w_gnt_vld ? req_wena_i[w_gnt_idx]  : 1'b0;
    assign mem_wdata_o = w_gnt_vld ? req_wdata_i[w_gnt_idx] : '0;

    assign req_rvld_o  = rvld_r;
    assign req_rdata_o = rdata_r;
    assign req_err_o   = err_r;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            ptr_r      <= '0;
            lock_vld_r <= 1'b0;
            lock_own_r <= '0;
            lock_cnt_r <= '0;
            rvld_r     <= '0;
            rdata_r    <= '0;
            err_r      <= 1'b0;
        end else begin
            rvld_r  <= req_gnt_o;
            err_r   <= w_gnt_vld & mem_err_i;
            rdata_r <= (w_gnt_vld && !req_wena_i[w_gnt_idx]) ? mem_rdata_i : '0;
            // An unrequested or exhausted lock drops here; the pointer only moves on a grant.
            if (w_hold) begin
                lock_vld_r <= 1'b1;
                lock_own_r <= w_gnt_idx;
                lock_cnt_r <= w_cnt_nxt;
            end else begin
                lock_vld_r <= 1'b0;
                lock_cnt_r <= '0;
                if (w_gnt_vld) begin
                    ptr_r <= (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
                end
            end
        end
    end

endmodule
